// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI master.
package sd_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned HALF_W  = 8;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned PULSE_W = 7;

  localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_CSL  = 3'd1,
    OP_CSH  = 3'd2,
    OP_FAST = 3'd3,
    OP_SLOW = 3'd4,
    OP_RD   = 3'd5,
    OP_WR   = 3'd6,
    OP_INIT = 3'd7
  } spiOP_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    XFER_LO = 3'd1,
    XFER_HI = 3'd2,
    INIT_LO = 3'd3,
    INIT_HI = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sd_clkdiv.sv
// SCLK half-period timer: reloads to half-1 on load, tick while the count sits at zero.
module sd_clkdiv
  import sd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HALF_W-1:0] i_half,
  output logic              o_tick_c
);

  logic [HALF_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_half - HALF_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HALF_W'(1);
    end
  end

  assign o_tick_c = (r_cnt == '0);

endmodule

// File: rtl/sd_spi.sv
// Byte-level SPI master (mode 0) for the SD-card controller: chip select,
// speed select, power-up clocking and full-duplex byte transfers.
module sd_spi
  import sd_pkg::*;
#(
  parameter int unsigned SLOW_HALF = 128,
  parameter int unsigned FAST_HALF = 4,
  parameter int unsigned INIT_CLKS = 80
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [OP_W-1:0] spiOP,
  input  logic [7:0]      spiTXD,
  output logic [7:0]      spiRXD,
  output logic            spiBUSY,
  output logic            spiDONE,
  output logic            sdCS,
  output logic            sdSCLK,
  output logic            sdMOSI,
  input  logic            sdMISO
);

  state_t               r_state, w_state_nxt;
  logic                 r_cs, w_cs;
  logic                 r_sclk, w_sclk;
  logic                 r_mosi, w_mosi;
  logic [7:0]           r_rxd, w_rxd;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_fast, w_fast;
  logic [7:0]           r_shreg, w_shreg;
  logic [BIT_W-1:0]     r_bitcnt, w_bitcnt;
  logic [PULSE_W-1:0]   r_pulse, w_pulse;
  logic                 w_load;
  logic                 w_tick;
  logic [HALF_W-1:0]    w_half;
  logic [7:0]           w_tx;
  spiOP_t               w_op;

  // Speed only changes from IDLE/DONE, so an op in flight keeps its rate.
  assign w_half = r_fast ? HALF_W'(FAST_HALF) : HALF_W'(SLOW_HALF);

  sd_clkdiv u_clkdiv (
    .clk      (clk),
    .rst      (reset),
    .i_load   (w_load),
    .i_half   (w_half),
    .o_tick_c (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cs        = r_cs;
    w_sclk      = r_sclk;
    w_mosi      = r_mosi;
    w_rxd       = r_rxd;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_fast      = r_fast;
    w_shreg     = r_shreg;
    w_bitcnt    = r_bitcnt;
    w_pulse     = r_pulse;
    w_load      = 1'b0;
    w_op        = spiOP_t'(spiOP);
    w_tx        = (w_op == OP_RD) ? SD_IDLE_BYTE : spiTXD;

    if (clear) begin
      w_state_nxt = IDLE;
      w_cs        = 1'b1;
      w_sclk      = 1'b0;
      w_mosi      = 1'b1;
      w_rxd       = SD_IDLE_BYTE;
      w_busy      = 1'b0;
      w_fast      = 1'b0;
      w_shreg     = SD_IDLE_BYTE;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE (back-to-back ops).
        IDLE, DONE: begin
          w_state_nxt = IDLE;
          case (w_op)
            OP_CSL:  begin w_cs = 1'b0;   w_done = 1'b1; w_state_nxt = DONE; end
            OP_CSH:  begin w_cs = 1'b1;   w_done = 1'b1; w_state_nxt = DONE; end
            OP_FAST: begin w_fast = 1'b1; w_done = 1'b1; w_state_nxt = DONE; end
            OP_SLOW: begin w_fast = 1'b0; w_done = 1'b1; w_state_nxt = DONE; end
            OP_RD, OP_WR: begin
              w_shreg     = w_tx;
              w_mosi      = w_tx[7];
              w_bitcnt    = BIT_W'(7);
              w_busy      = 1'b1;
              w_load      = 1'b1;
              w_state_nxt = XFER_LO;
            end
            OP_INIT: begin
              w_cs        = 1'b1;
              w_mosi      = 1'b1;
              w_pulse     = PULSE_W'(INIT_CLKS - 1);
              w_busy      = 1'b1;
              w_load      = 1'b1;
              w_state_nxt = INIT_LO;
            end
            default: ;
          endcase
        end
        XFER_LO: if (w_tick) begin
          w_sclk      = 1'b1;
          w_shreg     = {r_shreg[6:0], sdMISO};
          w_load      = 1'b1;
          w_state_nxt = XFER_HI;
        end
        XFER_HI: if (w_tick) begin
          w_sclk = 1'b0;
          if (r_bitcnt == '0) begin
            w_mosi      = 1'b1;
            w_rxd       = r_shreg;
            w_busy      = 1'b0;
            w_done      = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_bitcnt    = r_bitcnt - BIT_W'(1);
            w_mosi      = r_shreg[7];
            w_load      = 1'b1;
            w_state_nxt = XFER_LO;
          end
        end
        INIT_LO: if (w_tick) begin
          w_sclk      = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = INIT_HI;
        end
        INIT_HI: if (w_tick) begin
          w_sclk = 1'b0;
          if (r_pulse == '0) begin
            w_busy      = 1'b0;
            w_done      = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_pulse     = r_pulse - PULSE_W'(1);
            w_load      = 1'b1;
            w_state_nxt = INIT_LO;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_rxd    <= SD_IDLE_BYTE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fast   <= 1'b0;
      r_shreg  <= SD_IDLE_BYTE;
      r_bitcnt <= '0;
      r_pulse  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cs     <= w_cs;
      r_sclk   <= w_sclk;
      r_mosi   <= w_mosi;
      r_rxd    <= w_rxd;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_fast   <= w_fast;
      r_shreg  <= w_shreg;
      r_bitcnt <= w_bitcnt;
      r_pulse  <= w_pulse;
    end
  end

  assign spiRXD  = r_rxd;
  assign spiBUSY = r_busy;
  assign spiDONE = r_done;
  assign sdCS    = r_cs;
  assign sdSCLK  = r_sclk;
  assign sdMOSI  = r_mosi;

endmodule

// File: tb/tb_sd_spi.sv
// Bench for sd_spi: behavioural SD-card responder plus a scoreboard of
// expected done cycles and received bytes.
module tb_sd_spi;
  import sd_pkg::*;

  localparam int unsigned SLOW_HALF = 128;
  localparam int unsigned FAST_HALF = 4;
  localparam int unsigned INIT_CLKS = 80;
  localparam logic [12:0] RST_VEC   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [2:0] spiOP = 3'd0;
  logic [7:0] spiTXD = 8'h00;
  logic [7:0] spiRXD;
  logic       spiBUSY, spiDONE, sdCS, sdSCLK, sdMOSI;
  logic       sdMISO = 1'b1;

  always #5 clk = ~clk;

  sd_spi #(.SLOW_HALF(SLOW_HALF), .FAST_HALF(FAST_HALF), .INIT_CLKS(INIT_CLKS)) dut (
    .clk(clk), .reset(reset), .clear(clear), .spiOP(spiOP), .spiTXD(spiTXD),
    .spiRXD(spiRXD), .spiBUSY(spiBUSY), .spiDONE(spiDONE), .sdCS(sdCS),
    .sdSCLK(sdSCLK), .sdMOSI(sdMOSI), .sdMISO(sdMISO)
  );

  typedef struct {
    int         cyc;
    logic [7:0] rxd;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         rises = 0;
  int         init_bad = 0;
  logic [7:0] card_sh = 8'hFF;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] m_rxd = 8'hFF;
  bit         m_fast = 1'b0;

  task automatic count_cyc();
    forever begin @(posedge clk); cyc++; end
  endtask

  // Card shifts its next bit out on every falling SCLK (mode 0).
  task automatic card_model();
    forever begin
      @(negedge sdSCLK);
      card_sh = {card_sh[6:0], 1'b1};
      sdMISO  = card_sh[7];
    end
  endtask

  task automatic sclk_mon();
    forever begin
      @(posedge sdSCLK);
      mosi_cap = {mosi_cap[6:0], sdMOSI};
      rises++;
      if (sdCS !== 1'b1 || sdMOSI !== 1'b1) init_bad++;
    end
  endtask

  task automatic done_mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (spiDONE === 1'b1) begin
        done_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL done_cycle got %0d exp %0d", cyc, e.cyc);
          end
          checks++;
          if (spiRXD !== e.rxd) begin
            errors++;
            $display("FAIL done_rxd got %h exp %h", spiRXD, e.rxd);
          end
        end
      end
    end
  endtask

  // Call just after a falling clk edge; returns one cycle after acceptance.
  task automatic issue_op(input spiOP_t op, input logic [7:0] txd,
                          input logic [7:0] card, input bit expect_done);
    exp_t        ent;
    int unsigned h;
    h      = m_fast ? FAST_HALF : SLOW_HALF;
    spiOP  = op;
    spiTXD = txd;
    ent.rxd = m_rxd;
    ent.cyc = cyc + 1;
    if (op == OP_RD || op == OP_WR) begin
      card_sh = card;
      sdMISO  = card[7];
      ent.rxd = card;
      ent.cyc = cyc + 1 + int'(16 * h);
    end else if (op == OP_INIT) begin
      ent.cyc = cyc + 1 + int'(2 * INIT_CLKS * h);
    end
    if (expect_done) begin
      sb.push_back(ent);
      m_rxd = ent.rxd;
      if (op == OP_FAST) m_fast = 1'b1;
      if (op == OP_SLOW) m_fast = 1'b0;
    end
    @(negedge clk);
    spiOP = OP_NOP;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (sb.size() != 0 && n < max) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending %0d exp 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sdCS, sdSCLK, sdMOSI, spiBUSY, spiDONE, spiRXD} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values got %h exp %h",
               {sdCS, sdSCLK, sdMOSI, spiBUSY, spiDONE, spiRXD}, RST_VEC);
    end
    reset = 1'b0;
    @(negedge clk);
    issue_op(OP_WR, 8'h3C, 8'h00, 1'b0);
    repeat (200) @(negedge clk);
    checks++;
    if (sdSCLK !== 1'b1 || spiBUSY !== 1'b1) begin
      errors++;
      $display("FAIL midwr_active got sclk=%b busy=%b exp 1 1", sdSCLK, spiBUSY);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sdCS, sdSCLK, sdMOSI, spiBUSY, spiDONE, spiRXD} !== RST_VEC) begin
      errors++;
      $display("FAIL midwr_reset got %h exp %h",
               {sdCS, sdSCLK, sdMOSI, spiBUSY, spiDONE, spiRXD}, RST_VEC);
    end
    m_rxd  = 8'hFF;
    m_fast = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_init();
    int r0;
    @(negedge clk);
    r0 = rises;
    init_bad = 0;
    issue_op(OP_INIT, 8'h00, 8'hFF, 1'b1);
    wait_idle(30000, "init");
    checks++;
    if (rises - r0 != int'(INIT_CLKS)) begin
      errors++;
      $display("FAIL init_pulses got %0d exp %0d", rises - r0, INIT_CLKS);
    end
    checks++;
    if (init_bad != 0) begin
      errors++;
      $display("FAIL init_cs_mosi got %0d bad rises exp 0", init_bad);
    end
  endtask

  task automatic test_cmd0();
    logic [7:0] cmd [0:5];
    cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    @(negedge clk);
    issue_op(OP_CSL, 8'h00, 8'hFF, 1'b1);
    wait_idle(10, "csl");
    checks++;
    if (sdCS !== 1'b0) begin
      errors++;
      $display("FAIL csl_cs got %b exp 0", sdCS);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue_op(OP_WR, cmd[i], 8'hFF, 1'b1);
      wait_idle(3000, "cmd_wr");
      checks++;
      if (mosi_cap !== cmd[i]) begin
        errors++;
        $display("FAIL cmd_mosi got %h exp %h", mosi_cap, cmd[i]);
      end
    end
    @(negedge clk);
    issue_op(OP_RD, 8'h00, 8'hFF, 1'b1);
    wait_idle(3000, "rd1");
    @(negedge clk);
    issue_op(OP_RD, 8'h5A, 8'h01, 1'b1);
    wait_idle(3000, "rd2");
    checks++;
    if (mosi_cap !== 8'hFF || spiRXD !== 8'h01) begin
      errors++;
      $display("FAIL rd_r1 got mosi=%h rxd=%h exp ff 01", mosi_cap, spiRXD);
    end
  endtask

  task automatic test_fast();
    int r0;
    @(negedge clk);
    issue_op(OP_FAST, 8'h00, 8'hFF, 1'b1);
    wait_idle(10, "fast");
    @(negedge clk);
    r0 = rises;
    issue_op(OP_WR, 8'hA5, 8'h5A, 1'b1);
    checks++;
    if (spiBUSY !== 1'b1 || sdMOSI !== 1'b1 || sdSCLK !== 1'b0) begin
      errors++;
      $display("FAIL fast_start got busy=%b mosi=%b sclk=%b exp 1 1 0", spiBUSY, sdMOSI, sdSCLK);
    end
    wait_idle(200, "fast_wr");
    checks++;
    if (mosi_cap !== 8'hA5 || rises - r0 != 8) begin
      errors++;
      $display("FAIL fast_mosi got %h/%0d exp a5/8", mosi_cap, rises - r0);
    end
  endtask

  task automatic test_busy_ignore();
    int d0;
    @(negedge clk);
    d0 = done_cnt;
    issue_op(OP_WR, 8'h81, 8'h42, 1'b1);
    repeat (5) @(negedge clk);
    spiOP = OP_WR; spiTXD = 8'h00;
    @(negedge clk);
    spiOP = OP_CSH;
    @(negedge clk);
    spiOP = OP_NOP;
    wait_idle(200, "busy_wr");
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL busy_done_count got %0d exp 1", done_cnt - d0);
    end
    checks++;
    if (sdCS !== 1'b0 || mosi_cap !== 8'h81) begin
      errors++;
      $display("FAIL busy_ignored got cs=%b mosi=%h exp 0 81", sdCS, mosi_cap);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk);
    issue_op(OP_RD, 8'h00, 8'hC3, 1'b1);
    while (spiDONE !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL b2b_done timeout got %0d cycles exp <200", n);
    end
    issue_op(OP_CSH, 8'h00, 8'hFF, 1'b1);
    wait_idle(10, "b2b");
    checks++;
    if (sdCS !== 1'b1 || spiRXD !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_state got cs=%b rxd=%h exp 1 c3", sdCS, spiRXD);
    end
  endtask

  task automatic test_clear();
    int r0;
    int n = 0;
    @(negedge clk);
    issue_op(OP_CSL, 8'h00, 8'hFF, 1'b1);
    wait_idle(10, "clr_csl");
    @(negedge clk);
    r0 = rises;
    issue_op(OP_WR, 8'h77, 8'h00, 1'b0);
    while (rises - r0 < 5 && n < 200) begin @(negedge clk); n++; end
    // Clear arrives together with a request that must be dropped.
    clear = 1'b1;
    spiOP = OP_CSL;
    @(negedge clk);
    clear = 1'b0;
    spiOP = OP_NOP;
    m_rxd  = 8'hFF;
    m_fast = 1'b0;
    checks++;
    if ({sdCS, sdSCLK, sdMOSI, spiBUSY, spiDONE, spiRXD} !== RST_VEC) begin
      errors++;
      $display("FAIL clear_values got %h exp %h",
               {sdCS, sdSCLK, sdMOSI, spiBUSY, spiDONE, spiRXD}, RST_VEC);
    end
    repeat (3) @(negedge clk);
    issue_op(OP_RD, 8'h00, 8'h11, 1'b1);
    wait_idle(3000, "clr_slow_rd");
  endtask

  initial begin
    fork
      count_cyc();
      card_model();
      sclk_mon();
      done_mon();
    join_none
    test_reset();
    test_init();
    test_cmd0();
    test_fast();
    test_busy_ignore();
    test_back_to_back();
    test_clear();
    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
